// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcodes, FSM states, flag layout and command legality rules for the
// ALU execute controller.
package alu_seq_ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_INV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DEC = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_NOP = 4'd9;

    // Bit positions inside the {Z,C,V} flag vector
    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC_LO = 3'd1,
        ST_EXEC_HI = 3'd2,
        ST_FIX     = 3'd3,
        ST_WB      = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    // Per-command execution scratch: captured ALU results and carries
    typedef struct packed {
        logic [15:0] res;
        logic        c0;
        logic        c1;
        logic        c2;
        logic        z;
        logic        v;
    } exec_t;

    function automatic logic cmd_illegal(input logic [3:0] op, input logic wide,
                                         input logic rd_odd, input logic rs_odd,
                                         input logic wide_en);
        logic bad;
        bad = (op > OP_NOP);
        if (wide) begin
            bad = bad || !wide_en || !((op == OP_ADD) || (op == OP_SUB)) || rd_odd || rs_odd;
        end
        return bad;
    endfunction

    // Signed overflow of a 16-bit pair op from the operand/result sign bits
    function automatic logic wide_ovf(input logic [3:0] op, input logic a15,
                                      input logic b15, input logic r15);
        logic v;
        if (op == OP_ADD) v = (a15 == b15) && (r15 != a15);
        else              v = (a15 != b15) && (r15 != a15);
        return v;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_regfile.sv
// Register file for the execute controller: REG_CNT x 8, one pair write port,
// one direct load port, pair-wide async reads for rd/rs and a byte debug read.
module alu_seq_ctrl_regfile
    import alu_seq_ctrl_pkg::*;
#(
    parameter  int REG_CNT = 4,
    localparam int ADDR_W  = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic              wr_wide_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [15:0]       wr_data_i,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [15:0]       rd_pair_o,
    output logic [15:0]       rs_pair_o,
    output logic [7:0]        dbg_data_o
);

    logic [REG_CNT-1:0][7:0] regs_q;
    logic [ADDR_W-1:0]       wr_hi;
    logic [ADDR_W-1:0]       rd_hi;
    logic [ADDR_W-1:0]       rs_hi;

    // The upper byte of a pair lives at addr+1; only used for aligned pairs.
    assign wr_hi = wr_addr_i + ADDR_W'(1);
    assign rd_hi = rd_addr_i + ADDR_W'(1);
    assign rs_hi = rs_addr_i + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            if (ld_en_i) begin
                regs_q[ld_addr_i] <= ld_data_i;
            end
            if (wr_en_i) begin
                regs_q[wr_addr_i] <= wr_data_i[7:0];
                if (wr_wide_i) begin
                    regs_q[wr_hi] <= wr_data_i[15:8];
                end
            end
        end
    end

    assign rd_pair_o  = {regs_q[rd_hi], regs_q[rd_addr_i]};
    assign rs_pair_o  = {regs_q[rs_hi], regs_q[rs_addr_i]};
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Execute controller for the 8-bit ALU: accepts register commands, sequences
// one ALU pass per cycle (2-3 for 16-bit pair ADD/SUB) and commits at WB.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter  int REG_CNT = 4,
    parameter  bit WIDE_EN = 1'b1,
    localparam int ADDR_W  = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_rd_i,
    input  logic [ADDR_W-1:0] cmd_rs_i,
    input  logic              cmd_wide_i,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_data_i,
    input  logic [ADDR_W-1:0] dbg_sel_i,
    output logic [7:0]        dbg_data_o,
    output logic [7:0]        alu_a_o,
    output logic [7:0]        alu_b_o,
    output logic [3:0]        alu_op_o,
    output logic              alu_c_in_o,
    input  logic [7:0]        alu_res_i,
    input  logic              alu_c_out_i,
    input  logic              alu_zero_i,
    input  logic              alu_ovf_i,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        flags_o
);

    state_e            state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic              wide_q;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    exec_t             ex_q;
    logic [2:0]        flags_q;
    logic [2:0]        flags_d;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              illegal;
    logic              ld_fire;
    logic [15:0]       rd_pair;
    logic [15:0]       rs_pair;

    assign cmd_ready_o = (state_q == ST_IDLE) && !ld_en_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign ld_fire     = ld_en_i && (state_q == ST_IDLE);
    assign illegal     = cmd_illegal(cmd_op_i, cmd_wide_i, cmd_rd_i[0], cmd_rs_i[0], WIDE_EN);

    alu_seq_ctrl_regfile #(.REG_CNT(REG_CNT)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (state_q == ST_WB),
        .wr_wide_i  (wide_q),
        .wr_addr_i  (rd_q),
        .wr_data_i  (ex_q.res),
        .ld_en_i    (ld_fire),
        .ld_addr_i  (ld_addr_i),
        .ld_data_i  (ld_data_i),
        .rd_addr_i  (cmd_rd_i),
        .rs_addr_i  (cmd_rs_i),
        .dbg_addr_i (dbg_sel_i),
        .rd_pair_o  (rd_pair),
        .rs_pair_o  (rs_pair),
        .dbg_data_o (dbg_data_o)
    );

    // Flags committed at WB; wide ops rebuild Z/C/V from the whole pair.
    always_comb begin
        flags_d = '0;
        flags_d[FLG_Z] = ex_q.z;
        flags_d[FLG_C] = ex_q.c0;
        flags_d[FLG_V] = ex_q.v;
        if (wide_q) begin
            flags_d[FLG_Z] = (ex_q.res == 16'd0);
            flags_d[FLG_C] = ex_q.c1 | ex_q.c2;
            flags_d[FLG_V] = wide_ovf(op_q, a_q[15], b_q[15], ex_q.res[15]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            rd_q    <= '0;
            wide_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ex_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op_i;
                        rd_q   <= cmd_rd_i;
                        wide_q <= cmd_wide_i;
                        a_q    <= rd_pair;
                        b_q    <= rs_pair;
                        if (illegal) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC_LO;
                        end
                    end
                end
                ST_EXEC_LO: begin
                    ex_q.res[7:0] <= alu_res_i;
                    ex_q.c0       <= alu_c_out_i;
                    ex_q.z        <= alu_zero_i;
                    ex_q.v        <= alu_ovf_i;
                    if (wide_q) begin
                        state_q <= ST_EXEC_HI;
                    end else begin
                        state_q <= ST_WB;
                        done_q  <= 1'b1;
                    end
                end
                ST_EXEC_HI: begin
                    ex_q.res[15:8] <= alu_res_i;
                    ex_q.c1        <= alu_c_out_i;
                    ex_q.c2        <= 1'b0;
                    // A low-byte carry/borrow is folded in by one extra INC/DEC pass.
                    if (ex_q.c0) begin
                        state_q <= ST_FIX;
                    end else begin
                        state_q <= ST_WB;
                        done_q  <= 1'b1;
                    end
                end
                ST_FIX: begin
                    ex_q.res[15:8] <= alu_res_i;
                    ex_q.c2        <= alu_c_out_i;
                    state_q        <= ST_WB;
                    done_q         <= 1'b1;
                end
                ST_WB: begin
                    flags_q <= flags_d;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = OP_AND;
        case (state_q)
            ST_EXEC_LO: begin
                alu_a_o  = a_q[7:0];
                alu_b_o  = b_q[7:0];
                alu_op_o = op_q;
            end
            ST_EXEC_HI: begin
                alu_a_o  = a_q[15:8];
                alu_b_o  = b_q[15:8];
                alu_op_o = op_q;
            end
            ST_FIX: begin
                alu_a_o  = ex_q.res[15:8];
                alu_op_o = (op_q == OP_ADD) ? OP_INC : OP_DEC;
            end
            default: ;
        endcase
    end

    assign alu_c_in_o = 1'b0;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign flags_o    = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural ALU stands in for the real one, and a
// pair-level arithmetic model predicts registers, flags and latency.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_wide = 1'b0, ld_en = 1'b0;
    logic [3:0] cmd_op = 4'd0;
    logic [1:0] cmd_rd = 2'd0, cmd_rs = 2'd0, ld_addr = 2'd0, dbg_sel = 2'd0;
    logic [7:0] ld_data = 8'd0;
    logic       cmd_ready, done, err, alu_c_in, alu_c_out, alu_zero, alu_ovf;
    logic [3:0] alu_op;
    logic [7:0] dbg_data, alu_a, alu_b, alu_res;
    logic [2:0] flags;

    logic       nw_valid = 1'b0, nw_ld = 1'b0;
    logic       nw_ready, nw_cin, nw_cout, nw_zero, nw_ovf, nw_done, nw_err;
    logic [3:0] nw_aop;
    logic [7:0] nw_dbg, nw_a, nw_b, nw_res;
    logic [2:0] nw_flags;

    int checks = 0;
    int failures = 0;
    logic [7:0] mreg [4];
    logic [2:0] mflags;

    // Returns {zero, carry(bit 8 of 9-bit result), overflow, result}
    function automatic logic [10:0] alu8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        logic v;
        r = 9'd0;
        v = 1'b0;
        case (op)
            4'd0: r = {1'b0, a & b};
            4'd1: r = {1'b0, a | b};
            4'd2: r = {1'b0, a ^ b};
            4'd3: r = {1'b0, ~a};
            4'd4: begin r = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd5: begin r = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd6: begin r = {1'b0, a} + 9'd1; v = (a == 8'h7F); end
            4'd7: begin r = {1'b0, a} - 9'd1; v = (a == 8'h80); end
            4'd8: r = {1'b0, b};
            default: r = {1'b0, a};
        endcase
        return {(r[7:0] == 8'd0), r[8], v, r[7:0]};
    endfunction

    always_comb {alu_zero, alu_c_out, alu_ovf, alu_res} = alu8(alu_op, alu_a, alu_b);
    always_comb {nw_zero, nw_cout, nw_ovf, nw_res} = alu8(nw_aop, nw_a, nw_b);

    alu_seq_ctrl #(.REG_CNT(4), .WIDE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs_i(cmd_rs), .cmd_wide_i(cmd_wide),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .dbg_sel_i(dbg_sel),
        .dbg_data_o(dbg_data), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_c_in_o(alu_c_in), .alu_res_i(alu_res), .alu_c_out_i(alu_c_out),
        .alu_zero_i(alu_zero), .alu_ovf_i(alu_ovf), .done_o(done), .err_o(err), .flags_o(flags)
    );

    alu_seq_ctrl #(.REG_CNT(4), .WIDE_EN(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(nw_valid), .cmd_ready_o(nw_ready),
        .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs_i(cmd_rs), .cmd_wide_i(cmd_wide),
        .ld_en_i(nw_ld), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .dbg_sel_i(dbg_sel),
        .dbg_data_o(nw_dbg), .alu_a_o(nw_a), .alu_b_o(nw_b), .alu_op_o(nw_aop),
        .alu_c_in_o(nw_cin), .alu_res_i(nw_res), .alu_c_out_i(nw_cout),
        .alu_zero_i(nw_zero), .alu_ovf_i(nw_ovf), .done_o(nw_done), .err_o(nw_err), .flags_o(nw_flags)
    );

    function automatic logic [31:0] mrv();
        return {mreg[3], mreg[2], mreg[1], mreg[0]};
    endfunction

    // Reference: 16-bit pair arithmetic straight from the operation definition
    task automatic model_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic wide, output logic e_err, output int e_lat);
        logic [15:0] a, b, r;
        logic [16:0] s;
        logic [10:0] o;
        e_err = (op > 4'd9) || (wide && (!(op == 4'd4 || op == 4'd5) || rd[0] || rs[0]));
        e_lat = 1;
        if (e_err) return;
        if (!wide) begin
            o = alu8(op, mreg[rd], mreg[rs]);
            mreg[rd] = o[7:0];
            mflags = o[10:8];
            e_lat = 2;
        end else begin
            a = {mreg[{rd[1], 1'b1}], mreg[rd]};
            b = {mreg[{rs[1], 1'b1}], mreg[rs]};
            s = (op == 4'd4) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
            r = s[15:0];
            mreg[rd] = r[7:0];
            mreg[{rd[1], 1'b1}] = r[15:8];
            mflags = {(r == 16'd0), s[16],
                      (op == 4'd4) ? ((a[15] == b[15]) && (r[15] != a[15]))
                                   : ((a[15] != b[15]) && (r[15] != a[15]))};
            e_lat = ((op == 4'd4) ? (a[7:0] + b[7:0] > 255) : (a[7:0] < b[7:0])) ? 4 : 3;
        end
    endtask

    task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(posedge clk);
        #1 ld_en = 1'b0;
        mreg[addr] = data;
    endtask

    // Drives one command and observes its handshake; no judgement here.
    task automatic send_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic wide, output logic rdy0, output int lat,
                            output logic [1:0] de, output logic [2:0] after);
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_wide = wide; cmd_valid = 1'b1;
        #1 rdy0 = cmd_ready;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        de = 2'b00;
        while (lat < 8 && de == 2'b00) begin
            @(negedge clk);
            lat++;
            de = {done, err};
        end
        @(negedge clk);
        after = {cmd_ready, done, err};
    endtask

    task automatic read_regs(output logic [31:0] rv);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 rv[i*8 +: 8] = dbg_data;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rv;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mreg[i] = 8'd0;
        mflags = 3'd0;
        @(negedge clk);
        read_regs(rv);
        checks++;
        if ({cmd_ready, done, err, flags} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got ready/done/err/flags=%b want 100000", {cmd_ready, done, err, flags});
        end
        checks++;
        if (rv !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs got %h want 00000000", rv);
        end
    endtask

    task automatic test_or();
        logic r0; int lat; logic [1:0] de; logic [2:0] af; logic e; int el; logic [31:0] rv;
        do_load(2'd0, 8'h0F);
        do_load(2'd1, 8'hF0);
        model_cmd(OP_OR, 2'd0, 2'd1, 1'b0, e, el);
        send_cmd(OP_OR, 2'd0, 2'd1, 1'b0, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (!r0 || lat != 2 || de !== 2'b10 || af !== 3'b100) begin
            failures++;
            $display("FAIL or_handshake got rdy=%b lat=%0d done_err=%b after=%b want 1 2 10 100", r0, lat, de, af);
        end
        checks++;
        if (rv[7:0] !== 8'hFF || flags !== 3'b000) begin
            failures++;
            $display("FAIL or_result got R0=%h flags=%b want ff 000", rv[7:0], flags);
        end
    endtask

    task automatic test_add_dec();
        logic r0; int lat; logic [1:0] de; logic [2:0] af; logic e; int el; logic [31:0] rv;
        do_load(2'd0, 8'h7F);
        do_load(2'd1, 8'h01);
        model_cmd(OP_ADD, 2'd0, 2'd1, 1'b0, e, el);
        send_cmd(OP_ADD, 2'd0, 2'd1, 1'b0, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (lat != 2 || rv[7:0] !== 8'h80 || flags !== 3'b001) begin
            failures++;
            $display("FAIL add_ovf got lat=%0d R0=%h flags=%b want 2 80 001", lat, rv[7:0], flags);
        end
        model_cmd(OP_DEC, 2'd0, 2'd0, 1'b0, e, el);
        send_cmd(OP_DEC, 2'd0, 2'd0, 1'b0, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (lat != 2 || rv[7:0] !== 8'h7F || flags !== 3'b001) begin
            failures++;
            $display("FAIL dec got lat=%0d R0=%h flags=%b want 2 7f 001", lat, rv[7:0], flags);
        end
    endtask

    task automatic test_wide();
        logic r0; int lat; logic [1:0] de; logic [2:0] af; logic e; int el; logic [31:0] rv;
        do_load(2'd0, 8'hFF); do_load(2'd1, 8'h00); do_load(2'd2, 8'h01); do_load(2'd3, 8'h00);
        model_cmd(OP_ADD, 2'd0, 2'd2, 1'b1, e, el);
        send_cmd(OP_ADD, 2'd0, 2'd2, 1'b1, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (lat != 4 || de !== 2'b10 || rv !== 32'h0001_0100 || flags !== 3'b000) begin
            failures++;
            $display("FAIL wide_add_fix got lat=%0d de=%b regs=%h flags=%b want 4 10 00010100 000", lat, de, rv, flags);
        end
        do_load(2'd0, 8'h00); do_load(2'd1, 8'h00);
        model_cmd(OP_SUB, 2'd0, 2'd2, 1'b1, e, el);
        send_cmd(OP_SUB, 2'd0, 2'd2, 1'b1, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (lat != 4 || rv !== 32'h0001_FFFF || flags !== 3'b010) begin
            failures++;
            $display("FAIL wide_sub_fix got lat=%0d regs=%h flags=%b want 4 0001ffff 010", lat, rv, flags);
        end
        do_load(2'd0, 8'h00); do_load(2'd1, 8'h80); do_load(2'd2, 8'h00); do_load(2'd3, 8'h80);
        model_cmd(OP_ADD, 2'd0, 2'd2, 1'b1, e, el);
        send_cmd(OP_ADD, 2'd0, 2'd2, 1'b1, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (lat != 3 || af !== 3'b100 || rv !== 32'h8000_0000 || flags !== 3'b111) begin
            failures++;
            $display("FAIL wide_add_ovf got lat=%0d after=%b regs=%h flags=%b want 3 100 80000000 111", lat, af, rv, flags);
        end
    endtask

    task automatic test_illegal();
        logic r0; int lat; logic [1:0] de; logic [2:0] af; logic e; int el; logic [31:0] rv;
        logic [3:0] ops [3] = '{4'hC, OP_AND, OP_ADD};
        logic [1:0] rds [3] = '{2'd0, 2'd0, 2'd1};
        logic       wds [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            model_cmd(ops[i], rds[i], 2'd2, wds[i], e, el);
            send_cmd(ops[i], rds[i], 2'd2, wds[i], r0, lat, de, af);
            read_regs(rv);
            checks++;
            if (!e || lat != 1 || de !== 2'b01 || af !== 3'b100 || rv !== mrv() || flags !== mflags) begin
                failures++;
                $display("FAIL illegal[%0d] got lat=%0d de=%b after=%b regs=%h flags=%b want 1 01 100 %h %b",
                         i, lat, de, af, rv, flags, mrv(), mflags);
            end
        end
    endtask

    task automatic test_wide_disabled();
        logic r0; logic [1:0] s1; logic [5:0] s2;
        @(negedge clk);
        cmd_op = OP_ADD; cmd_rd = 2'd0; cmd_rs = 2'd2; cmd_wide = 1'b1; nw_valid = 1'b1;
        #1 r0 = nw_ready;
        @(posedge clk);
        #1 nw_valid = 1'b0;
        @(negedge clk);
        s1 = {nw_err, nw_done};
        @(negedge clk);
        s2 = {nw_ready, nw_err, nw_done, nw_flags};
        checks++;
        if (!r0 || s1 !== 2'b10 || s2 !== 6'b100000) begin
            failures++;
            $display("FAIL wide_disabled got rdy=%b err_done=%b next=%b want 1 10 100000", r0, s1, s2);
        end
    endtask

    task automatic test_reset_mid_op();
        logic d_any; logic [31:0] rv;
        do_load(2'd0, 8'hFF); do_load(2'd1, 8'h00); do_load(2'd2, 8'h01); do_load(2'd3, 8'h00);
        @(negedge clk);
        cmd_op = OP_ADD; cmd_rd = 2'd0; cmd_rs = 2'd2; cmd_wide = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_a !== 8'hFF || alu_b !== 8'h01 || alu_op !== OP_ADD) begin
            failures++;
            $display("FAIL alu_lo_pass got a=%h b=%h op=%h want ff 01 4", alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== OP_ADD) begin
            failures++;
            $display("FAIL alu_hi_pass got a=%h b=%h op=%h want 00 00 4", alu_a, alu_b, alu_op);
        end
        rst_n = 1'b0;
        d_any = done;
        @(posedge clk);
        #1 d_any |= done;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mreg[i] = 8'd0;
        mflags = 3'd0;
        repeat (3) begin
            @(negedge clk);
            d_any |= done;
        end
        read_regs(rv);
        checks++;
        if (d_any || rv !== 32'd0 || flags !== 3'd0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_op got done_seen=%b regs=%h flags=%b ready=%b want 0 00000000 000 1", d_any, rv, flags, cmd_ready);
        end
    endtask

    task automatic test_ld_priority();
        logic r0, r_ld; int lat; logic [1:0] de; logic [2:0] af; logic e; int el; logic [31:0] rv;
        do_load(2'd1, 8'h03);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h05;
        cmd_op = OP_ADD; cmd_rd = 2'd0; cmd_rs = 2'd1; cmd_wide = 1'b0; cmd_valid = 1'b1;
        #1 r_ld = cmd_ready;
        @(posedge clk);
        #1 ld_en = 1'b0;
        mreg[0] = 8'h05;
        model_cmd(OP_ADD, 2'd0, 2'd1, 1'b0, e, el);
        send_cmd(OP_ADD, 2'd0, 2'd1, 1'b0, r0, lat, de, af);
        read_regs(rv);
        checks++;
        if (r_ld !== 1'b0 || !r0 || lat != 2 || rv[7:0] !== 8'h08) begin
            failures++;
            $display("FAIL ld_priority got ready_ld=%b ready_next=%b lat=%0d R0=%h want 0 1 2 08", r_ld, r0, lat, rv[7:0]);
        end
    endtask

    task automatic test_random();
        logic r0; int lat; logic [1:0] de; logic [2:0] af; logic e; int el; logic [31:0] rv;
        logic [3:0] op; logic [1:0] rd, rs; logic wide;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) do_load(2'($urandom_range(0, 3)), 8'($urandom));
            op   = 4'($urandom_range(0, 11));
            wide = ($urandom_range(0, 2) == 0);
            if (wide && $urandom_range(0, 3) != 0) op = $urandom_range(0, 1) ? OP_ADD : OP_SUB;
            rd = 2'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3));
            if (wide && $urandom_range(0, 3) != 0) begin rd[0] = 1'b0; rs[0] = 1'b0; end
            model_cmd(op, rd, rs, wide, e, el);
            send_cmd(op, rd, rs, wide, r0, lat, de, af);
            read_regs(rv);
            checks++;
            if (!r0 || lat != el || de !== {!e, e} || af !== 3'b100) begin
                failures++;
                $display("FAIL rand_hs[%0d] op=%h rd=%0d rs=%0d w=%b got rdy=%b lat=%0d de=%b after=%b want lat=%0d err=%b",
                         n, op, rd, rs, wide, r0, lat, de, af, el, e);
            end
            checks++;
            if (rv !== mrv() || flags !== mflags) begin
                failures++;
                $display("FAIL rand_state[%0d] op=%h rd=%0d rs=%0d w=%b got regs=%h flags=%b want %h %b",
                         n, op, rd, rs, wide, rv, flags, mrv(), mflags);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wide_disabled();
        test_or();
        test_add_dec();
        test_wide();
        test_illegal();
        test_reset_mid_op();
        test_ld_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
